combat_scheduler: RTL

//   Sequences one fighting round. Arbitrates player attack requests against CPU attack slots,

---
 rtl/combat_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/combat_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : combat_scheduler
// Brief    : Fighting-round sequencer; arbitrates player attacks against CPU
//            attack slots and owns both health registers. Optional round
//            timer enabled by defining ROUND_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module combat_scheduler #(
    parameter int START_HEALTH = 100,
    parameter int CPU_PERIOD   = 10_000_000,
    parameter int P1_COOLDOWN  = 2_500_000,
    parameter int TICK_CYCLES  = 10_000_000,
    parameter int ROUND_SECS   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_req,
    input  logic [3:0] p1_type,
    input  logic [1:0] p1_roll,
    input  logic [1:0] cpu_roll,
    output logic       p1_grant,
    output logic       cpu_isAttacking,
    output logic [7:0] p1_health_out,
    output logic [7:0] cpu_health_out,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [6:0] round_time
);
    localparam int c_CPU_W  = (CPU_PERIOD > 1) ? $clog2(CPU_PERIOD) : 1;
    localparam int c_COOL_W = (P1_COOLDOWN > 0) ? $clog2(P1_COOLDOWN + 1) : 1;
    localparam logic [7:0]          c_START    = 8'(START_HEALTH);
    localparam logic [c_CPU_W-1:0]  c_CPU_LAST = c_CPU_W'(CPU_PERIOD - 1);
    localparam logic [c_COOL_W-1:0] c_COOL     = c_COOL_W'(P1_COOLDOWN);
    localparam logic [3:0] c_LIGHT = 4'b0001;
    localparam logic [3:0] c_HEAVY = 4'b0010;
    localparam logic [1:0] c_CRIT  = 2'b01;
    localparam logic [1:0] c_NORM  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIGHT = 2'd1,
        S_KO    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_p1_health;
    logic [7:0]          r_cpu_health;
    logic [c_CPU_W-1:0]  r_cpu_cnt;
    logic [c_COOL_W-1:0] r_cool_cnt;
    logic                r_cpu_pend;
    logic                r_p1_grant;
    logic                r_cpu_att;
    logic [1:0]          r_winner;

    logic       w_fight, w_ko, w_active, w_start_round, w_wrap;
    logic       w_p1_go, w_cpu_go, w_cpu_hit, w_expire;
    logic [7:0] w_dmg_to_cpu, w_dmg_to_p1;
    logic [7:0] w_p1_health_nxt, w_cpu_health_nxt;

    function automatic logic [7:0] f_sat_sub(input logic [7:0] h, input logic [7:0] d);
        return (h > d) ? h - d : 8'd0;
    endfunction

    assign w_fight       = (r_state == S_FIGHT);
    // A zero health seen in FIGHT ends the round before any further event applies.
    assign w_ko          = w_fight && ((r_p1_health == 8'd0) || (r_cpu_health == 8'd0));
    assign w_active      = w_fight && !w_ko;
    assign w_start_round = start && (r_state != S_FIGHT);
    assign w_wrap        = w_active && (r_cpu_cnt == c_CPU_LAST);
    assign w_p1_go       = w_active && p1_req && (r_cool_cnt == '0) &&
                           ((p1_type == c_LIGHT) || (p1_type == c_HEAVY));
    assign w_cpu_go      = w_active && !w_p1_go && r_cpu_pend;
    assign w_cpu_hit     = w_cpu_go && ((cpu_roll == c_CRIT) || (cpu_roll == c_NORM));

    always_comb begin
        w_dmg_to_cpu = 8'd0;
        w_dmg_to_p1  = 8'd0;
        if (p1_roll == c_CRIT) begin
            w_dmg_to_cpu = (p1_type == c_HEAVY) ? 8'd4 : 8'd2;
        end else if (p1_roll == c_NORM) begin
            w_dmg_to_cpu = (p1_type == c_HEAVY) ? 8'd2 : 8'd1;
        end
        if (cpu_roll == c_CRIT) begin
            w_dmg_to_p1 = 8'd6;
        end else if (cpu_roll == c_NORM) begin
            w_dmg_to_p1 = 8'd5;
        end
    end

    assign w_cpu_health_nxt = w_p1_go  ? f_sat_sub(r_cpu_health, w_dmg_to_cpu) : r_cpu_health;
    assign w_p1_health_nxt  = w_cpu_go ? f_sat_sub(r_p1_health, w_dmg_to_p1)   : r_p1_health;

`ifdef ROUND_TIMER_EN
    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [6:0]          c_SECS      = 7'(ROUND_SECS);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [6:0]          r_round_time;
    logic                w_tick;

    assign w_tick   = w_active && (r_tick_cnt == c_TICK_LAST) && (r_round_time != 7'd0);
    assign w_expire = w_tick && (r_round_time == 7'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt   <= '0;
            r_round_time <= 7'd0;
        end else if (w_start_round) begin
            r_tick_cnt   <= '0;
            r_round_time <= c_SECS;
        end else if (w_tick) begin
            r_tick_cnt   <= '0;
            r_round_time <= r_round_time - 7'd1;
        end else if (w_active) begin
            r_tick_cnt   <= r_tick_cnt + 1'b1;
        end
    end

    assign round_time = r_round_time;
`else
    assign w_expire   = 1'b0;
    assign round_time = 7'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_KO: if (start)             w_state_nxt = S_FIGHT;
            S_FIGHT:      if (w_ko || w_expire)  w_state_nxt = S_KO;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_health  <= c_START;
            r_cpu_health <= c_START;
            r_cpu_cnt    <= '0;
            r_cool_cnt   <= '0;
            r_cpu_pend   <= 1'b0;
            r_p1_grant   <= 1'b0;
            r_cpu_att    <= 1'b0;
            r_winner     <= 2'b00;
        end else begin
            r_p1_grant <= w_p1_go;
            r_cpu_att  <= w_cpu_hit;
            if (w_start_round) begin
                r_p1_health  <= c_START;
                r_cpu_health <= c_START;
                r_cpu_cnt    <= '0;
                r_cool_cnt   <= '0;
                r_cpu_pend   <= 1'b0;
                r_winner     <= 2'b00;
            end else if (w_ko) begin
                r_cpu_pend <= 1'b0;
                r_winner   <= {r_p1_health == 8'd0, r_cpu_health == 8'd0};
            end else if (w_active) begin
                r_p1_health  <= w_p1_health_nxt;
                r_cpu_health <= w_cpu_health_nxt;
                r_cpu_cnt    <= w_wrap ? '0 : r_cpu_cnt + 1'b1;
                if (w_p1_go) begin
                    r_cool_cnt <= c_COOL;
                end else if (r_cool_cnt != '0) begin
                    r_cool_cnt <= r_cool_cnt - 1'b1;
                end
                // At most one slot pending; a held slot survives a new wrap unchanged.
                r_cpu_pend <= ((r_cpu_pend && !w_cpu_go) || w_wrap) && !w_expire;
                if (w_expire) begin
                    if (w_p1_health_nxt > w_cpu_health_nxt) begin
                        r_winner <= 2'b01;
                    end else if (w_cpu_health_nxt > w_p1_health_nxt) begin
                        r_winner <= 2'b10;
                    end else begin
                        r_winner <= 2'b11;
                    end
                end
            end
        end
    end

    assign p1_grant        = r_p1_grant;
    assign cpu_isAttacking = r_cpu_att;
    assign p1_health_out   = r_p1_health;
    assign cpu_health_out  = r_cpu_health;
    assign game_over       = (r_state == S_KO);
    assign winner          = r_winner;

endmodule
`default_nettype wire
